// File: rtl/boot_ram_ctrl_if.sv
// Boot RAM controller bus bundle: loader, CPU memory port and RAM port.
// slave is the controller view, master is the surrounding system view.
interface boot_ram_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_done;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_run;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic [ADDR_W:0]   load_count;
    logic              load_err;

    modport slave (
        input  ld_we, ld_addr, ld_data, ld_done,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ram_rdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_run,
        output ram_we, ram_addr, ram_wdata,
        output load_count, load_err
    );

    modport master (
        output ld_we, ld_addr, ld_data, ld_done,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ram_rdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_run,
        input  ram_we, ram_addr, ram_wdata,
        input  load_count, load_err
    );
endinterface

// File: rtl/boot_ram_ctrl.sv
// Boot sequencer owning the single RAM port: loader writes in LOAD,
// a settle delay, then the RAM port is handed to the CPU in RUN.
module boot_ram_ctrl #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MAX_WORDS = 256,
    parameter int RUN_DELAY = 4
) (
    input  logic           clock,
    input  logic           reset,
    boot_ram_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_LOAD, S_SETTLE, S_RUN} state_e;
    typedef enum logic [1:0] {T_IDLE, T_ISSUE, T_RDATA} txn_e;

    localparam int CW = (RUN_DELAY > 1) ? $clog2(RUN_DELAY) : 1;
    localparam logic [ADDR_W:0] MAX_CNT  = (ADDR_W+1)'(MAX_WORDS);
    localparam logic [CW-1:0]   DLY_LAST = CW'(RUN_DELAY - 1);

    state_e            state_q, state_d;
    txn_e              txn_q, txn_d;
    logic [CW-1:0]     dly_q, dly_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              gnt_q, gnt_d;
    logic              rvalid_q, rvalid_d;
    logic              run_q, run_d;
    logic              err_q, err_d;

    always_comb begin
        state_d     = state_q;
        txn_d       = txn_q;
        dly_d       = dly_q;
        cnt_d       = cnt_q;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        gnt_d       = 1'b0;
        rvalid_d    = 1'b0;
        err_d       = err_q;
        unique case (state_q)
            S_LOAD: begin
                if (bus.ld_we) begin
                    ram_we_d    = 1'b1;
                    ram_addr_d  = bus.ld_addr;
                    ram_wdata_d = bus.ld_data;
                    if (cnt_q != MAX_CNT) cnt_d = cnt_q + 1'b1;
                end
                if (bus.ld_done || (bus.ld_we && cnt_d == MAX_CNT))
                    state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (dly_q == DLY_LAST) state_d = S_RUN;
                else dly_d = dly_q + 1'b1;
            end
            S_RUN: begin
                unique case (txn_q)
                    T_IDLE: begin
                        if (bus.cpu_req) begin
                            txn_d       = T_ISSUE;
                            ram_we_d    = bus.cpu_we;
                            ram_addr_d  = bus.cpu_addr;
                            ram_wdata_d = bus.cpu_wdata;
                            gnt_d       = 1'b1;
                        end
                    end
                    // a read is the issued access that did not write
                    T_ISSUE: begin
                        if (!ram_we_q) begin
                            txn_d    = T_RDATA;
                            rvalid_d = 1'b1;
                        end else begin
                            txn_d = T_IDLE;
                        end
                    end
                    default: txn_d = T_IDLE;
                endcase
            end
            default: state_d = S_LOAD;
        endcase
        if (state_q != S_LOAD && bus.ld_we) err_d = 1'b1;
        run_d = (state_d == S_RUN);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_LOAD;
            txn_q       <= T_IDLE;
            dly_q       <= '0;
            cnt_q       <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            gnt_q       <= 1'b0;
            rvalid_q    <= 1'b0;
            run_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            txn_q       <= txn_d;
            dly_q       <= dly_d;
            cnt_q       <= cnt_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            gnt_q       <= gnt_d;
            rvalid_q    <= rvalid_d;
            run_q       <= run_d;
            err_q       <= err_d;
        end
    end

    assign bus.ram_we     = ram_we_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_wdata  = ram_wdata_q;
    assign bus.cpu_gnt    = gnt_q;
    assign bus.cpu_rvalid = rvalid_q;
    assign bus.cpu_run    = run_q;
    assign bus.load_count = cnt_q;
    assign bus.load_err   = err_q;
    // RAM output is already a register; gate it so rdata is 0 outside RDATA
    assign bus.cpu_rdata  = rvalid_q ? bus.ram_rdata : '0;
endmodule

// File: tb/tb_boot_ram_ctrl.sv
// Bench for boot_ram_ctrl: vector table for load/settle/run entry,
// scoreboard queues for RAM writes and CPU read data.
module tb_boot_ram_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    boot_ram_ctrl_if #(.ADDR_W(8), .DATA_W(8)) a ();
    boot_ram_ctrl_if #(.ADDR_W(8), .DATA_W(8)) b ();

    boot_ram_ctrl #(.ADDR_W(8), .DATA_W(8), .MAX_WORDS(256), .RUN_DELAY(4))
        u_a (.clock(clock), .reset(reset), .bus(a));
    boot_ram_ctrl #(.ADDR_W(8), .DATA_W(8), .MAX_WORDS(4), .RUN_DELAY(4))
        u_b (.clock(clock), .reset(reset), .bus(b));

    logic [7:0] mem_a [256];
    always @(posedge clock) begin
        if (a.ram_we) mem_a[a.ram_addr] <= a.ram_wdata;
        a.ram_rdata <= mem_a[a.ram_addr];
    end
    assign b.ram_rdata = '0;

    int n_chk = 0;
    int n_pass = 0;
    int b_writes = 0;
    logic [15:0] wq[$];
    logic [7:0]  rq[$];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    always @(negedge clock) begin
        if (a.ram_we) begin
            if (wq.size() == 0) begin
                n_chk++;
                $display("FAIL ram_write_unexpected: got %0h@%0h expected none",
                         a.ram_wdata, a.ram_addr);
            end else begin
                check("ram_write", {a.ram_addr, a.ram_wdata}, wq.pop_front());
            end
        end
        if (a.cpu_rvalid) begin
            if (rq.size() == 0) begin
                n_chk++;
                $display("FAIL rvalid_unexpected: got rdata %0h expected none",
                         a.cpu_rdata);
            end else begin
                check("cpu_rdata_sb", a.cpu_rdata, rq.pop_front());
            end
        end
        if (b.ram_we) b_writes++;
    end

    typedef struct {
        logic       ld_we;
        logic [7:0] ld_addr;
        logic [7:0] ld_data;
        logic       ld_done;
        logic       req;
        logic       e_we;
        logic [7:0] e_addr;
        logic [7:0] e_data;
        logic [8:0] e_cnt;
        logic       e_run;
        logic       e_gnt;
    } vec_t;

    vec_t tv[11];

    function automatic vec_t mk(logic we, logic [7:0] ad, logic [7:0] dt,
                                logic dn, logic rq_, logic ewe,
                                logic [7:0] ea, logic [7:0] ed,
                                logic [8:0] ec, logic er, logic eg);
        vec_t v;
        v.ld_we = we; v.ld_addr = ad; v.ld_data = dt; v.ld_done = dn;
        v.req = rq_; v.e_we = ewe; v.e_addr = ea; v.e_data = ed;
        v.e_cnt = ec; v.e_run = er; v.e_gnt = eg;
        return v;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic cpu_read(input logic [7:0] addr, input logic [7:0] exp);
        a.cpu_req = 1'b1; a.cpu_we = 1'b0; a.cpu_addr = addr;
        rq.push_back(exp);
        step();
        check("rd_gnt", a.cpu_gnt, 1);
        check("rd_ram_we", a.ram_we, 0);
        check("rd_ram_addr", a.ram_addr, addr);
        check("rd_rvalid_early", a.cpu_rvalid, 0);
        a.cpu_req = 1'b0;
        step();
        check("rd_rvalid", a.cpu_rvalid, 1);
        check("rd_rdata", a.cpu_rdata, exp);
        check("rd_gnt_pulse", a.cpu_gnt, 0);
        step();
        check("rd_rvalid_pulse", a.cpu_rvalid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        a.ld_we = 0; a.ld_addr = 0; a.ld_data = 0; a.ld_done = 0;
        a.cpu_req = 0; a.cpu_we = 0; a.cpu_addr = 0; a.cpu_wdata = 0;
        b.ld_we = 0; b.ld_addr = 0; b.ld_data = 0; b.ld_done = 0;
        b.cpu_req = 0; b.cpu_we = 0; b.cpu_addr = 0; b.cpu_wdata = 0;

        tv[0]  = mk(1, 8'h00, 8'hA0, 0, 1, 1, 8'h00, 8'hA0, 1, 0, 0);
        tv[1]  = mk(1, 8'h01, 8'hA1, 0, 1, 1, 8'h01, 8'hA1, 2, 0, 0);
        tv[2]  = mk(1, 8'h02, 8'hA2, 0, 1, 1, 8'h02, 8'hA2, 3, 0, 0);
        tv[3]  = mk(1, 8'h03, 8'hA3, 0, 1, 1, 8'h03, 8'hA3, 4, 0, 0);
        tv[4]  = mk(1, 8'h04, 8'hA4, 1, 1, 1, 8'h04, 8'hA4, 5, 0, 0);
        tv[5]  = mk(0, 8'h00, 8'h00, 0, 1, 0, 8'h04, 8'hA4, 5, 0, 0);
        tv[6]  = mk(0, 8'h00, 8'h00, 0, 1, 0, 8'h04, 8'hA4, 5, 0, 0);
        tv[7]  = mk(0, 8'h00, 8'h00, 0, 1, 0, 8'h04, 8'hA4, 5, 0, 0);
        tv[8]  = mk(0, 8'h00, 8'h00, 0, 1, 0, 8'h04, 8'hA4, 5, 1, 0);
        tv[9]  = mk(0, 8'h00, 8'h00, 0, 1, 1, 8'h10, 8'h5A, 5, 1, 1);
        tv[10] = mk(0, 8'h00, 8'h00, 0, 0, 0, 8'h10, 8'h5A, 5, 1, 0);

        repeat (2) step();
        check("rst_ram_we", a.ram_we, 0);
        check("rst_ram_addr", a.ram_addr, 0);
        check("rst_ram_wdata", a.ram_wdata, 0);
        check("rst_gnt", a.cpu_gnt, 0);
        check("rst_rvalid", a.cpu_rvalid, 0);
        check("rst_run", a.cpu_run, 0);
        check("rst_count", a.load_count, 0);
        check("rst_err", a.load_err, 0);
        reset = 1'b1;

        for (int i = 0; i < 3; i++) begin
            a.ld_we = 1; a.ld_addr = 8'h20 + 8'(i); a.ld_data = 8'h30 + 8'(i);
            wq.push_back({a.ld_addr, a.ld_data});
            step();
        end
        a.ld_we = 0;
        step();
        check("t1_count_pre", a.load_count, 3);
        reset = 1'b0;
        #2;
        check("t1_count", a.load_count, 0);
        check("t1_ram_addr", a.ram_addr, 0);
        check("t1_ram_wdata", a.ram_wdata, 0);
        check("t1_ram_we", a.ram_we, 0);
        check("t1_run", a.cpu_run, 0);
        step();
        reset = 1'b1;

        a.cpu_we = 1; a.cpu_addr = 8'h10; a.cpu_wdata = 8'h5A;
        for (int i = 0; i < 11; i++) begin
            a.ld_we = tv[i].ld_we; a.ld_addr = tv[i].ld_addr;
            a.ld_data = tv[i].ld_data; a.ld_done = tv[i].ld_done;
            a.cpu_req = tv[i].req;
            if (tv[i].e_we) wq.push_back({tv[i].e_addr, tv[i].e_data});
            step();
            check($sformatf("v%0d ram_we", i), a.ram_we, tv[i].e_we);
            check($sformatf("v%0d ram_addr", i), a.ram_addr, tv[i].e_addr);
            check($sformatf("v%0d ram_wdata", i), a.ram_wdata, tv[i].e_data);
            check($sformatf("v%0d count", i), a.load_count, tv[i].e_cnt);
            check($sformatf("v%0d run", i), a.cpu_run, tv[i].e_run);
            check($sformatf("v%0d gnt", i), a.cpu_gnt, tv[i].e_gnt);
        end
        a.ld_we = 0; a.ld_done = 0; a.cpu_req = 0;

        cpu_read(8'h10, 8'h5A);
        cpu_read(8'h02, 8'hA2);

        a.ld_done = 1;
        step();
        a.ld_done = 0;
        check("run_done_no_err", a.load_err, 0);
        a.ld_we = 1; a.ld_addr = 8'h30; a.ld_data = 8'h99;
        step();
        a.ld_we = 0;
        check("run_ld_we_err", a.load_err, 1);
        check("run_ld_we_no_write", a.ram_we, 0);
        check("run_ld_we_count", a.load_count, 5);
        step();
        check("err_sticky", a.load_err, 1);

        a.cpu_req = 1; a.cpu_we = 0; a.cpu_addr = 8'h02;
        step();
        check("t6_gnt", a.cpu_gnt, 1);
        a.cpu_req = 0;
        #2 reset = 1'b0;
        #1;
        check("t6_rvalid", a.cpu_rvalid, 0);
        check("t6_run", a.cpu_run, 0);
        check("t6_err", a.load_err, 0);
        step();
        step();
        check("t6_rvalid_late", a.cpu_rvalid, 0);
        reset = 1'b1;
        a.ld_we = 1; a.ld_addr = 8'h07; a.ld_data = 8'h77;
        wq.push_back({8'h07, 8'h77});
        step();
        a.ld_we = 0;
        check("t6_load_we", a.ram_we, 1);
        check("t6_load_count", a.load_count, 1);

        b_writes = 0;
        for (int i = 0; i < 6; i++) begin
            b.ld_we = 1; b.ld_addr = 8'(i); b.ld_data = 8'h10 + 8'(i);
            step();
        end
        b.ld_we = 0;
        step();
        check("t3_writes", b_writes, 4);
        check("t3_count", b.load_count, 4);
        check("t3_err", b.load_err, 1);
        check("t3_last_addr", b.ram_addr, 3);
        check("t3_last_data", b.ram_wdata, 8'h13);

        step();
        check("wq_empty", wq.size(), 0);
        check("rq_empty", rq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
